// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, exception codes
// and the alignment rule.
package mem_pkg;

    typedef enum logic [1:0] {
        SzByte  = 2'd0,
        SzHalf  = 2'd1,
        SzWord  = 2'd2,
        SzDword = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam logic [1:0] ExcNone     = 2'd0;
    localparam logic [1:0] ExcMisalign = 2'd1;
    localparam logic [1:0] ExcTimeout  = 2'd2;

    localparam int unsigned CntW = 10;

    // A dword on a 32-bit datapath has no legal alignment, so it is flagged too.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr,
                                        input logic dword_ok);
        logic m;
        case (size)
            SzByte:  m = 1'b0;
            SzHalf:  m = addr[0];
            SzWord:  m = |addr[1:0];
            default: m = !dword_ok || (|addr);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes, store data replication and load extract/extend.
// Purely combinational.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]                   size,
    input  logic [$clog2(DATA_W/8)-1:0]  lane,
    input  logic                         sign,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W-1:0]            rdata,
    output logic [DATA_W/8-1:0]          wstrb,
    output logic [DATA_W-1:0]            wdata_rep,
    output logic [DATA_W-1:0]            rdata_ext
);
    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [NB-1:0]     base;
    logic              msb;

    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        base      = '0;
        mask      = '0;
        msb       = 1'b0;
        wdata_rep = '0;
        case (size)
            SzByte: begin
                base      = NB'(1);
                mask      = DATA_W'(64'hFF);
                msb       = shifted[7];
                wdata_rep = {NB{wdata[7:0]}};
            end
            SzHalf: begin
                base      = NB'(3);
                mask      = DATA_W'(64'hFFFF);
                msb       = shifted[15];
                wdata_rep = {(NB/2){wdata[15:0]}};
            end
            SzWord: begin
                base      = NB'(15);
                mask      = DATA_W'(64'hFFFF_FFFF);
                msb       = shifted[31];
                wdata_rep = {(DATA_W/32){wdata[31:0]}};
            end
            default: begin
                base      = '1;
                mask      = '1;
                msb       = shifted[DATA_W-1];
                wdata_rep = wdata;
            end
        endcase
    end

    assign wstrb     = base << lane;
    assign rdata_ext = (shifted & mask) | ((sign && msb) ? ~mask : '0);

endmodule

// File: rtl/mem_hs.sv
// MEM pipeline stage: valid/allowin handshake with EX and WB, request/response
// handshake with data memory, alignment and timeout exceptions.
module mem_hs
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ctl_mem_valid_i,
    output logic                ctl_mem_allowin_o,
    input  logic                ex_load_i,
    input  logic                ex_store_i,
    input  logic                ex_sign_i,
    input  logic [1:0]          ex_size_i,
    input  logic [31:0]         ex_addr_i,
    input  logic [DATA_W-1:0]   ex_wdata_i,
    input  logic [4:0]          ex_dest_i,
    input  logic                ex_we_i,
    input  logic [31:0]         ex_pc_i,
    output logic                dm_req_o,
    output logic                dm_wr_o,
    output logic [31:0]         dm_addr_o,
    output logic [DATA_W/8-1:0] dm_wstrb_o,
    output logic [DATA_W-1:0]   dm_wdata_o,
    input  logic                dm_addr_ok_i,
    input  logic                dm_data_ok_i,
    input  logic [DATA_W-1:0]   dm_rdata_i,
    output logic                wb_valid_o,
    input  logic                wb_allowin_i,
    output logic [4:0]          wb_dest_o,
    output logic                wb_we_o,
    output logic [DATA_W-1:0]   wb_result_o,
    output logic [31:0]         wb_pc_o,
    output logic                wb_excp_o,
    output logic [1:0]          wb_excp_code_o,
    output logic [4:0]          ctl_mem_dest_o
);
    localparam int unsigned LB = $clog2(DATA_W / 8);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              load_q, store_q, sign_q, we_q, excp_q;
    logic [1:0]        size_q, code_q;
    logic [31:0]       addr_q, pc_q;
    logic [DATA_W-1:0] wdata_q, result_q;
    logic [4:0]        dest_q;

    logic              accept, is_mem, mis, to_hit, timeout_ev, data_ev;
    logic [CntW:0]     cnt_up;
    logic [DATA_W/8-1:0] strb;
    logic [DATA_W-1:0] wdata_rep, rdata_ext;

    assign is_mem = ex_load_i | ex_store_i;
    assign mis    = misaligned(ex_size_i, ex_addr_i[2:0], DATA_W == 64);
    assign accept = ctl_mem_valid_i & ctl_mem_allowin_o;
    assign cnt_up = {1'b0, cnt_q} + 1'b1;
    assign to_hit = cnt_up >= (CntW + 1)'(TIMEOUT);

    // Handshake progress wins over the timeout when both land on the same cycle.
    assign timeout_ev = ((state_q == StReq) && !dm_addr_ok_i && to_hit) ||
                        ((state_q == StWait) && !dm_data_ok_i && to_hit);
    assign data_ev    = (state_q == StWait) && dm_data_ok_i;

    mem_lane_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .size      (size_q),
        .lane      (addr_q[LB-1:0]),
        .sign      (sign_q),
        .wdata     (wdata_q),
        .rdata     (dm_rdata_i),
        .wstrb     (strb),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StReq: begin
                cnt_d = cnt_up[CntW-1:0];
                if (dm_addr_ok_i)  state_d = StWait;
                else if (to_hit)   state_d = StDone;
            end
            StWait: begin
                cnt_d = cnt_up[CntW-1:0];
                if (dm_data_ok_i || to_hit) state_d = StDone;
            end
            StDone: if (wb_allowin_i) state_d = StIdle;
            default: ;
        endcase
        if (accept) begin
            cnt_d   = '0;
            state_d = (is_mem && !mis) ? StReq : StDone;
        end
    end

    always_comb begin
        ctl_mem_allowin_o = (state_q == StIdle) || ((state_q == StDone) && wb_allowin_i);
        dm_req_o          = (state_q == StReq);
        dm_wr_o           = dm_req_o && store_q;
        dm_addr_o         = dm_req_o ? addr_q : '0;
        dm_wstrb_o        = dm_wr_o ? strb : '0;
        dm_wdata_o        = dm_wr_o ? wdata_rep : '0;
        wb_valid_o        = (state_q == StDone);
        ctl_mem_dest_o    = ((state_q != StIdle) && we_q) ? dest_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            sign_q   <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            pc_q     <= '0;
            wdata_q  <= '0;
            dest_q   <= '0;
            result_q <= '0;
            excp_q   <= 1'b0;
            code_q   <= ExcNone;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                load_q   <= ex_load_i;
                store_q  <= ex_store_i;
                sign_q   <= ex_sign_i;
                we_q     <= ex_we_i;
                size_q   <= ex_size_i;
                addr_q   <= ex_addr_i;
                pc_q     <= ex_pc_i;
                wdata_q  <= ex_wdata_i;
                dest_q   <= ex_dest_i;
                excp_q   <= is_mem && mis;
                code_q   <= (is_mem && mis) ? ExcMisalign : ExcNone;
                result_q <= is_mem ? '0 : DATA_W'(ex_addr_i);
            end else if (timeout_ev) begin
                excp_q   <= 1'b1;
                code_q   <= ExcTimeout;
                result_q <= '0;
            end else if (data_ev) begin
                result_q <= load_q ? rdata_ext : '0;
            end
        end
    end

    assign wb_dest_o      = dest_q;
    assign wb_we_o        = we_q && !excp_q;
    assign wb_result_o    = result_q;
    assign wb_pc_o        = pc_q;
    assign wb_excp_o      = excp_q;
    assign wb_excp_code_o = code_q;

endmodule

// File: tb/tb_mem_hs.sv
// Directed bench for mem_hs: a 32-bit instance with a short timeout and a 64-bit
// instance share stimulus; each is enabled through its own valid input.
module tb_mem_hs;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        ex_load = 1'b0, ex_store = 1'b0, ex_sign = 1'b0, ex_we = 1'b0;
    logic [1:0]  ex_size = '0;
    logic [31:0] ex_addr = '0, ex_pc = '0;
    logic [63:0] ex_wdata = '0, rdata = '0;
    logic [4:0]  ex_dest = '0;
    logic        addr_ok = 1'b0, data_ok = 1'b0, wb_allowin = 1'b0;

    logic        a_allowin, a_req, a_wr, a_wb_valid, a_we, a_excp;
    logic [31:0] a_addr, a_wdata, a_result, a_pc;
    logic [3:0]  a_wstrb;
    logic [4:0]  a_dest, a_ctl_dest;
    logic [1:0]  a_code;

    logic        b_allowin, b_req, b_wr, b_wb_valid, b_we, b_excp;
    logic [31:0] b_addr, b_pc;
    logic [63:0] b_wdata, b_result;
    logic [7:0]  b_wstrb;
    logic [4:0]  b_dest, b_ctl_dest;
    logic [1:0]  b_code;

    int checks = 0;
    int errors = 0;
    int b_xfers = 0;
    logic [63:0] b_res[$];

    always #5 clk = ~clk;

    mem_hs #(.DATA_W(32), .TIMEOUT(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .ctl_mem_valid_i(valid_a), .ctl_mem_allowin_o(a_allowin),
        .ex_load_i(ex_load), .ex_store_i(ex_store), .ex_sign_i(ex_sign),
        .ex_size_i(ex_size), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata[31:0]),
        .ex_dest_i(ex_dest), .ex_we_i(ex_we), .ex_pc_i(ex_pc),
        .dm_req_o(a_req), .dm_wr_o(a_wr), .dm_addr_o(a_addr), .dm_wstrb_o(a_wstrb),
        .dm_wdata_o(a_wdata), .dm_addr_ok_i(addr_ok), .dm_data_ok_i(data_ok),
        .dm_rdata_i(rdata[31:0]), .wb_valid_o(a_wb_valid), .wb_allowin_i(wb_allowin),
        .wb_dest_o(a_dest), .wb_we_o(a_we), .wb_result_o(a_result), .wb_pc_o(a_pc),
        .wb_excp_o(a_excp), .wb_excp_code_o(a_code), .ctl_mem_dest_o(a_ctl_dest)
    );

    mem_hs #(.DATA_W(64), .TIMEOUT(255)) u_b (
        .clk(clk), .rst_n(rst_n),
        .ctl_mem_valid_i(valid_b), .ctl_mem_allowin_o(b_allowin),
        .ex_load_i(ex_load), .ex_store_i(ex_store), .ex_sign_i(ex_sign),
        .ex_size_i(ex_size), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
        .ex_dest_i(ex_dest), .ex_we_i(ex_we), .ex_pc_i(ex_pc),
        .dm_req_o(b_req), .dm_wr_o(b_wr), .dm_addr_o(b_addr), .dm_wstrb_o(b_wstrb),
        .dm_wdata_o(b_wdata), .dm_addr_ok_i(addr_ok), .dm_data_ok_i(data_ok),
        .dm_rdata_i(rdata), .wb_valid_o(b_wb_valid), .wb_allowin_i(wb_allowin),
        .wb_dest_o(b_dest), .wb_we_o(b_we), .wb_result_o(b_result), .wb_pc_o(b_pc),
        .wb_excp_o(b_excp), .wb_excp_code_o(b_code), .ctl_mem_dest_o(b_ctl_dest)
    );

    // Every WB handshake of the 64-bit instance, in order.
    always @(posedge clk) begin
        if (rst_n && b_wb_valid && wb_allowin) begin
            b_xfers++;
            b_res.push_back(b_result);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_op(input logic ld, input logic st, input logic sg, input logic [1:0] sz,
                          input logic [31:0] ad, input logic [63:0] wd, input logic [4:0] ds,
                          input logic we);
        ex_load  = ld;
        ex_store = st;
        ex_sign  = sg;
        ex_size  = sz;
        ex_addr  = ad;
        ex_wdata = wd;
        ex_dest  = ds;
        ex_we    = we;
        ex_pc    = ad + 32'h1000;
    endtask

    initial begin
        tick();
        check("rst_allowin_a", a_allowin, 1);
        check("rst_wbvalid_a", a_wb_valid, 0);
        check("rst_req_a", a_req, 0);
        check("rst_result_a", a_result, 0);
        check("rst_allowin_b", b_allowin, 1);
        check("rst_ctldest_b", b_ctl_dest, 0);
        rst_n = 1'b1;
        tick();

        // ALU op
        set_op(0, 0, 0, 2'd0, 32'h1234, 0, 5'd5, 1);
        valid_a = 1; wb_allowin = 1;
        check("alu_allowin", a_allowin, 1);
        tick();
        valid_a = 0;
        check("alu_valid", a_wb_valid, 1);
        check("alu_result", a_result, 64'h1234);
        check("alu_we", a_we, 1);
        check("alu_dest", a_dest, 5);
        check("alu_ctldest", a_ctl_dest, 5);
        check("alu_pc", a_pc, 32'h2234);
        tick();
        check("alu_drain", a_wb_valid, 0);

        // Signed byte load, then back-to-back unsigned byte load
        set_op(1, 0, 1, 2'd0, 32'h103, 0, 5'd6, 1);
        rdata = 64'h80FF_FFFF; addr_ok = 1; data_ok = 1; valid_a = 1;
        tick();
        valid_a = 0;
        check("lb_req", a_req, 1);
        check("lb_wr", a_wr, 0);
        check("lb_wstrb", a_wstrb, 0);
        check("lb_addr", a_addr, 32'h103);
        tick();
        check("lb_wait_valid", a_wb_valid, 0);
        check("lb_wait_req", a_req, 0);
        tick();
        check("lb_valid", a_wb_valid, 1);
        check("lb_result", a_result, 64'hFFFF_FF80);
        check("lb_excp", a_excp, 0);
        set_op(1, 0, 0, 2'd0, 32'h103, 0, 5'd6, 1);
        valid_a = 1;
        tick();
        valid_a = 0;
        check("lbu_b2b_valid", a_wb_valid, 0);
        check("lbu_b2b_req", a_req, 1);
        tick();
        tick();
        check("lbu_valid", a_wb_valid, 1);
        check("lbu_result", a_result, 64'h80);
        tick();

        // Half store held while addr_ok is low
        set_op(0, 1, 0, 2'd1, 32'h102, 64'hABCD, 5'd0, 0);
        addr_ok = 0; data_ok = 0; valid_a = 1;
        tick();
        valid_a = 0;
        check("sh_req", a_req, 1);
        check("sh_wr", a_wr, 1);
        check("sh_wstrb", a_wstrb, 4'b1100);
        check("sh_wdata", a_wdata, 64'hABCD_ABCD);
        tick();
        check("sh_hold_wstrb", a_wstrb, 4'b1100);
        check("sh_hold_addr", a_addr, 32'h102);
        addr_ok = 1;
        tick();
        check("sh_wait_req", a_req, 0);
        addr_ok = 0; data_ok = 1;
        tick();
        data_ok = 0;
        check("sh_valid", a_wb_valid, 1);
        check("sh_excp", a_excp, 0);
        tick();

        // Misaligned word load
        set_op(1, 0, 0, 2'd2, 32'h102, 0, 5'd7, 1);
        valid_a = 1;
        tick();
        valid_a = 0;
        check("mis_req", a_req, 0);
        check("mis_valid", a_wb_valid, 1);
        check("mis_excp", a_excp, 1);
        check("mis_code", a_code, 1);
        check("mis_we", a_we, 0);
        tick();

        // Timeout with addr_ok never asserted
        set_op(1, 0, 0, 2'd2, 32'h100, 0, 5'd8, 1);
        valid_a = 1;
        tick();
        valid_a = 0;
        for (int i = 0; i < 4; i++) begin
            check("to_req", a_req, 1);
            check("to_notdone", a_wb_valid, 0);
            tick();
        end
        check("to_valid", a_wb_valid, 1);
        check("to_excp", a_excp, 1);
        check("to_code", a_code, 2);
        check("to_req_drop", a_req, 0);
        check("to_result", a_result, 0);
        check("to_we", a_we, 0);
        tick();

        // Asynchronous reset in the middle of a request
        set_op(1, 0, 0, 2'd2, 32'h200, 0, 5'd9, 1);
        valid_a = 1;
        tick();
        valid_a = 0;
        check("rstmid_req", a_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_req_off", a_req, 0);
        check("rstmid_allowin", a_allowin, 1);
        tick();
        rst_n = 1'b1;
        addr_ok = 1; data_ok = 1;
        tick();
        check("rstmid_novalid1", a_wb_valid, 0);
        tick();
        check("rstmid_novalid2", a_wb_valid, 0);
        check("rstmid_noreq", a_req, 0);

        // 64-bit word store at upper lane
        set_op(0, 1, 0, 2'd2, 32'hC, 64'hDEAD_BEEF, 5'd0, 0);
        valid_b = 1; wb_allowin = 1;
        tick();
        valid_b = 0;
        check("sw64_wstrb", b_wstrb, 8'hF0);
        check("sw64_wdata", b_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
        check("sw64_wr", b_wr, 1);
        tick();
        tick();
        check("sw64_valid", b_wb_valid, 1);
        tick();

        // Dword load followed by an ALU op while WB stalls intermittently
        set_op(1, 0, 0, 2'd3, 32'h8, 0, 5'd7, 1);
        rdata = 64'h1122_3344_5566_7788;
        valid_b = 1; wb_allowin = 0;
        tick();
        set_op(0, 0, 0, 2'd0, 32'h55, 0, 5'd9, 1);
        check("ld64_allowin_req", b_allowin, 0);
        check("ld64_req", b_req, 1);
        check("ld64_addr", b_addr, 32'h8);
        tick();
        check("ld64_allowin_wait", b_allowin, 0);
        tick();
        check("ld64_valid", b_wb_valid, 1);
        check("ld64_result", b_result, 64'h1122_3344_5566_7788);
        check("ld64_allowin_stall", b_allowin, 0);
        tick();
        check("ld64_hold_valid", b_wb_valid, 1);
        check("ld64_hold_result", b_result, 64'h1122_3344_5566_7788);
        wb_allowin = 1;
        #1;
        check("ld64_allowin_go", b_allowin, 1);
        tick();
        valid_b = 0; wb_allowin = 0;
        check("alu64_valid", b_wb_valid, 1);
        check("alu64_result", b_result, 64'h55);
        check("alu64_dest", b_dest, 9);
        tick();
        check("alu64_hold", b_result, 64'h55);
        wb_allowin = 1;
        tick();
        check("alu64_drain", b_wb_valid, 0);
        check("b_xfer_count", b_xfers, 3);
        if (b_res.size() == 3) begin
            check("b_xfer0", b_res[0], 0);
            check("b_xfer1", b_res[1], 64'h1122_3344_5566_7788);
            check("b_xfer2", b_res[2], 64'h55);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
